mem_wb_stage: RTL

Pipeline stage directly downstream of the memory stage. It takes the memory stage's pass-through PC, the ALU result and the load data, and selects the writeback value. It registers the result with a valid/ready handshake and a one-entry skid buffer, so the register-file write port can back-pressure without losing an instruction. It also drives the forwarding bus back to execute.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/wb_skid_buf.sv | 74 +++++++
 rtl/mem_wb_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared writeback-path types: entry layout, skid-buffer state encoding and
// the load/ALU writeback selection.
package pipe_pkg;

  localparam int PC_W      = 13;
  localparam int DATA_W    = 32;
  // Destination width carried in the entry; widen here if REG_AW grows past 5.
  localparam int WB_REG_AW = 5;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [DATA_W-1:0]    data;
    logic                 reg_write;
    logic [WB_REG_AW-1:0] wreg;
  } wb_entry_t;

  // Bit 0 = main entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_MAIN  = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_e;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_read,
    input logic [DATA_W-1:0] read_data,
    input logic [DATA_W-1:0] alu_res
  );
    return mem_read ? read_data : alu_res;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry valid/ready buffer (main + skid) over wb_entry_t with flush.
// Handshake: a transfer happens at a rising edge when valid & ready are both
// high; in_ready is a flop output (skid empty), out valid never looks at ready.
module wb_skid_buf
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  wb_entry_t  in_entry,
  input  logic       out_ready,
  output wb_entry_t  out_entry,
  output buf_state_e state_o
);

  buf_state_e state_q, state_d;
  wb_entry_t  main_q, main_d;
  wb_entry_t  skid_q, skid_d;
  logic       in_ready;
  logic       accept;

  assign in_ready = (state_q != BUF_FULL);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = BUF_MAIN;
        end
      end
      BUF_MAIN: begin
        if (out_ready) begin
          if (accept) main_d = in_entry;
          else        state_d = BUF_EMPTY;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        // Skid never bypasses main: it only ever refills main.
        if (out_ready) begin
          main_d  = skid_q;
          state_d = BUF_MAIN;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    // Flush only kills valid state; payload may stay stale.
    if (flush) state_d = BUF_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_entry = main_q;
  assign state_o   = state_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: writeback select, skid-buffered handshake,
// forwarding bus. Optional retire counter under MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] ALURes,
  input  logic [DATA_W-1:0] ReadData,
  input  logic              Mem_Read,
  input  logic              Reg_Write,
  input  logic [REG_AW-1:0] WriteReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   PCOut,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWriteOut,
  output logic [REG_AW-1:0] WriteRegOut,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retire_cnt
);

  wb_entry_t  in_entry;
  wb_entry_t  out_entry;
  buf_state_e buf_state;

  // Selection happens at capture so only the chosen value is stored.
  always_comb begin
    in_entry           = '0;
    in_entry.pc        = PC;
    in_entry.data      = wb_select(Mem_Read, ReadData, ALURes);
    in_entry.reg_write = Reg_Write;
    in_entry.wreg      = WB_REG_AW'(WriteReg);
  end

  wb_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .out_ready (out_ready),
    .out_entry (out_entry),
    .state_o   (buf_state)
  );

  assign in_ready    = (buf_state != BUF_FULL);
  assign out_valid   = (buf_state != BUF_EMPTY);
  assign PCOut       = out_entry.pc;
  assign WriteData   = out_entry.data;
  assign RegWriteOut = out_entry.reg_write;
  assign WriteRegOut = REG_AW'(out_entry.wreg);

  // Register 0 is hardwired, so it is never a forwarding source.
  assign fwd_valid = out_valid & RegWriteOut & (WriteRegOut != '0);
  assign fwd_reg   = WriteRegOut;
  assign fwd_data  = WriteData;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (out_valid & out_ready) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retire_cnt_q <= '0;
    else      retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule
